// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite renderer.
// Included by the animation controller and the pixel datapath.
package sprite_pkg;

  typedef logic [7:0]  rgb332_t;
  typedef logic [10:0] coord_t;

  localparam rgb332_t KEY_COLOR_DEF = 8'h00;

  function automatic int lat(input int rom_latency);
    return 2 + rom_latency;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Vblank-synchronised config shadow and animation frame sequencer.
// Requested config is latched only on frame_start for tear-free updates.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FRAME_DIV  = 8,
  parameter int MAX_FRAMES = 8,
  localparam int FW = $clog2(MAX_FRAMES) + 1,
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              update,
  input  logic              enable,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  input  logic [ADDR_W-1:0] sprite_num,
  input  logic [FW-1:0]     anim_frames,
  input  logic              anim_en,
  input  logic              mirror_x,
  output coord_t            act_x,
  output coord_t            act_y,
  output logic [ADDR_W-1:0] act_base,
  output logic              act_mirror,
  output logic              act_en,
  output logic [FW-1:0]     frame_idx
);

  logic          pending;
  logic          act_anim;
  logic [FW-1:0] act_frames;
  logic [DW-1:0] div_cnt;
  logic          load;
  logic          step;
  logic          div_wrap;
  logic          idx_wrap;

  assign load     = frame_start & (pending | update);
  assign step     = frame_start & act_anim
                  & (act_frames >= FW'(2));
  assign div_wrap = (div_cnt == DW'(FRAME_DIV - 1));
  assign idx_wrap = (frame_idx == act_frames - FW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_x      <= '0;
      act_y      <= '0;
      act_base   <= '0;
      act_mirror <= 1'b0;
      act_en     <= 1'b0;
      act_anim   <= 1'b0;
      act_frames <= '0;
      pending    <= 1'b0;
      frame_idx  <= '0;
      div_cnt    <= '0;
    end else if (load) begin
      act_x      <= pos_x;
      act_y      <= pos_y;
      act_base   <= sprite_num;
      act_mirror <= mirror_x;
      act_en     <= enable;
      act_anim   <= anim_en;
      act_frames <= anim_frames;
      pending    <= 1'b0;
      frame_idx  <= '0;
      div_cnt    <= '0;
    end else begin
      if (update) pending <= 1'b1;
      if (step) begin
        if (div_wrap) begin
          div_cnt   <= '0;
          frame_idx <= idx_wrap ? '0 : frame_idx + FW'(1);
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_pipe_renderer.sv
// Pipelined sprite pixel generator: box test, ROM address, key/opaque out.
// Valid bit rides a delay line matched to the sprite ROM read latency.
module sprite_pipe_renderer
  import sprite_pkg::*;
#(
  parameter int      SPR_W        = 32,
  parameter int      SPR_H        = 32,
  parameter int      SHEET_STRIDE = 600,
  parameter int      ADDR_W       = 16,
  parameter int      ROM_LATENCY  = 1,
  parameter rgb332_t KEY_COLOR    = KEY_COLOR_DEF,
  parameter int      FRAME_DIV    = 8,
  parameter int      MAX_FRAMES   = 8,
  localparam int FW = $clog2(MAX_FRAMES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  coord_t            hc,
  input  coord_t            vc,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              enable,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  input  logic [ADDR_W-1:0] sprite_num,
  input  logic [FW-1:0]     anim_frames,
  input  logic              anim_en,
  input  logic              mirror_x,
  input  logic              update,
  input  rgb332_t           mem_value,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        R,
  output logic [2:0]        G,
  output logic [1:0]        B,
  output logic              hit
);

  coord_t            x0;
  coord_t            y0;
  logic [ADDR_W-1:0] base;
  logic              mirror;
  logic              en;
  logic [FW-1:0]     frame_idx;

  sprite_anim_ctrl #(
    .ADDR_W     (ADDR_W),
    .FRAME_DIV  (FRAME_DIV),
    .MAX_FRAMES (MAX_FRAMES)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .update      (update),
    .enable      (enable),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .sprite_num  (sprite_num),
    .anim_frames (anim_frames),
    .anim_en     (anim_en),
    .mirror_x    (mirror_x),
    .act_x       (x0),
    .act_y       (y0),
    .act_base    (base),
    .act_mirror  (mirror),
    .act_en      (en),
    .frame_idx   (frame_idx)
  );

  // 12-bit bounds so a box hanging past 2047 does not wrap to column 0
  logic [11:0] hc_e, vc_e, x0_e, y0_e, x_end, y_end;
  logic        in_box;
  coord_t      lx, ly, xm;
  logic [ADDR_W-1:0] addr_nxt;
  logic        v_nxt;

  assign hc_e  = {1'b0, hc};
  assign vc_e  = {1'b0, vc};
  assign x0_e  = {1'b0, x0};
  assign y0_e  = {1'b0, y0};
  assign x_end = x0_e + 12'(SPR_W);
  assign y_end = y0_e + 12'(SPR_H);

  assign in_box = (hc_e >= x0_e) && (hc_e < x_end)
               && (vc_e >= y0_e) && (vc_e < y_end);

  assign lx = hc - x0;
  assign ly = vc - y0;
  assign xm = mirror ? (11'(SPR_W - 1) - lx) : lx;

  assign addr_nxt = in_box
    ? base
      + ADDR_W'(frame_idx) * ADDR_W'(SPR_W)
      + ADDR_W'(ly) * ADDR_W'(SHEET_STRIDE)
      + ADDR_W'(xm)
    : base;

  assign v_nxt = in_box & ~blank & en;

  logic [ROM_LATENCY:0] vp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      vp       <= '0;
      R        <= '0;
      G        <= '0;
      B        <= '0;
      hit      <= 1'b0;
    end else begin
      rom_addr <= addr_nxt;
      vp       <= {vp[ROM_LATENCY-1:0], v_nxt};
      if (vp[ROM_LATENCY] && (mem_value != KEY_COLOR)) begin
        {R, G, B} <= mem_value;
        hit       <= 1'b1;
      end else begin
        {R, G, B} <= '0;
        hit       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pipe_renderer.sv
// Directed bench for sprite_pipe_renderer at ROM latency 1 and 3.
// Both instances share stimulus; each has its own ROM read pipeline.
module tb_sprite_pipe_renderer;
  import sprite_pkg::*;

  localparam int LAT1 = lat(1);
  localparam int LAT3 = lat(3);

  logic        clk = 1'b0;
  logic        rst_n;
  coord_t      hc, vc, pos_x, pos_y;
  logic        blank, frame_start, enable;
  logic [15:0] sprite_num;
  logic [3:0]  anim_frames;
  logic        anim_en, mirror_x, update;

  logic [7:0]  mem1, m3a, m3b, mem3;
  logic [15:0] addr1, addr3;
  logic [2:0]  r1, g1, r3, g3;
  logic [1:0]  b1, b3;
  logic        hit1, hit3;

  logic [7:0]  rom [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem1 <= rom[addr1];
    m3a  <= rom[addr3];
    m3b  <= m3a;
    mem3 <= m3b;
  end

  sprite_pipe_renderer #(.ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc),
    .blank(blank), .frame_start(frame_start),
    .enable(enable), .pos_x(pos_x), .pos_y(pos_y),
    .sprite_num(sprite_num), .anim_frames(anim_frames),
    .anim_en(anim_en), .mirror_x(mirror_x),
    .update(update), .mem_value(mem1),
    .rom_addr(addr1), .R(r1), .G(g1), .B(b1), .hit(hit1)
  );

  sprite_pipe_renderer #(.ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc),
    .blank(blank), .frame_start(frame_start),
    .enable(enable), .pos_x(pos_x), .pos_y(pos_y),
    .sprite_num(sprite_num), .anim_frames(anim_frames),
    .anim_en(anim_en), .mirror_x(mirror_x),
    .update(update), .mem_value(mem3),
    .rom_addr(addr3), .R(r3), .G(g3), .B(b3), .hit(hit3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag,
                     input int x, input int y,
                     input logic [15:0] ea,
                     input logic eh,
                     input logic [7:0] ec);
    hc = 11'(x);
    vc = 11'(y);
    @(posedge clk); #1;
    chk({tag, ".addr1"}, addr1, ea);
    chk({tag, ".addr3"}, addr3, ea);
    hc = '0;
    vc = '0;
    repeat (LAT1 - 1) @(posedge clk);
    #1;
    chk({tag, ".hit1"}, hit1, eh);
    chk({tag, ".rgb1"}, {r1, g1, b1}, ec);
    chk({tag, ".early3"}, hit3, 1'b0);
    repeat (LAT3 - LAT1) @(posedge clk);
    #1;
    chk({tag, ".hit3"}, hit3, eh);
    chk({tag, ".rgb3"}, {r3, g3, b3}, ec);
  endtask

  task automatic cfg(input int x, input int y,
                     input logic [15:0] base,
                     input logic [3:0] fr,
                     input logic an, input logic mx);
    pos_x       = 11'(x);
    pos_y       = 11'(y);
    sprite_num  = base;
    anim_frames = fr;
    anim_en     = an;
    mirror_x    = mx;
    enable      = 1'b1;
    update      = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    update      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fs(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      rom[i] = 8'(i) ^ 8'hE0;
    rst_n = 1'b0;
    hc = '0; vc = '0; blank = 1'b0;
    frame_start = 1'b0; enable = 1'b0;
    pos_x = '0; pos_y = '0; sprite_num = '0;
    anim_frames = '0; anim_en = 1'b0;
    mirror_x = 1'b0; update = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.addr", addr1, 16'h0);
    chk("rst.hit1", hit1, 1'b0);
    chk("rst.rgb1", {r1, g1, b1}, 8'h00);
    chk("rst.hit3", hit3, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cfg(100, 50, 16'h0, 4'd0, 1'b0, 1'b0);
    pix("t1.tl", 100, 50, 16'd0, 1'b1, 8'hE0);
    pix("t2.br", 131, 81, 16'd18631, 1'b1, 8'h27);
    pix("t2.xr", 132, 81, 16'd0, 1'b0, 8'h00);
    pix("t2.yb", 100, 82, 16'd0, 1'b0, 8'h00);
    pix("t2.xl", 99, 50, 16'd0, 1'b0, 8'h00);

    rom[31] = 8'h00;
    cfg(100, 50, 16'h0, 4'd0, 1'b0, 1'b1);
    pix("t3.key", 100, 50, 16'd31, 1'b0, 8'h00);
    pix("t3.mr", 131, 50, 16'd0, 1'b1, 8'hE0);

    pos_x    = 11'd200;
    mirror_x = 1'b0;
    update   = 1'b1;
    @(posedge clk); #1;
    update   = 1'b0;
    pix("t4.old", 101, 50, 16'd30, 1'b1, 8'hFE);
    pix("t4.nox", 200, 50, 16'd0, 1'b0, 8'h00);
    fs(1);
    pix("t4.new", 200, 50, 16'd0, 1'b1, 8'hE0);
    pix("t4.gone", 100, 50, 16'd0, 1'b0, 8'h00);

    cfg(200, 50, 16'h0, 4'd3, 1'b1, 1'b0);
    pix("t5.f0", 200, 50, 16'd0, 1'b1, 8'hE0);
    fs(7);
    pix("t5.f0b", 200, 50, 16'd0, 1'b1, 8'hE0);
    fs(1);
    pix("t5.f1", 200, 50, 16'd32, 1'b1, 8'hC0);
    fs(8);
    pix("t5.f2", 200, 50, 16'd64, 1'b1, 8'hA0);
    fs(8);
    pix("t5.wrap", 200, 50, 16'd0, 1'b1, 8'hE0);

    cfg(200, 50, 16'h0, 4'd1, 1'b1, 1'b0);
    fs(8);
    pix("t5.one", 200, 50, 16'd0, 1'b1, 8'hE0);

    cfg(200, 50, 16'hFFFF, 4'd0, 1'b0, 1'b0);
    pix("trunc.a", 200, 50, 16'hFFFF, 1'b1, 8'h1F);
    pix("trunc.b", 201, 50, 16'h0000, 1'b1, 8'hE0);

    blank = 1'b1;
    pix("t6.blank", 201, 50, 16'd0, 1'b0, 8'h00);
    blank = 1'b0;

    hc = 11'd201;
    vc = 11'd50;
    repeat (6) @(posedge clk);
    #1;
    chk("t6.pre.hit1", hit1, 1'b1);
    chk("t6.pre.hit3", hit3, 1'b1);
    chk("t6.pre.rgb3", {r3, g3, b3}, 8'hE0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6.rst.hit1", hit1, 1'b0);
    chk("t6.rst.hit3", hit3, 1'b0);
    chk("t6.rst.rgb1", {r1, g1, b1}, 8'h00);
    chk("t6.rst.addr", addr1, 16'h0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t6.post.hit1", hit1, 1'b0);
    chk("t6.post.hit3", hit3, 1'b0);
    chk("t6.post.addr", addr3, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
